// File: rtl/display_manager_if.sv
// Pixel-stream bundle between the display sequencer and its environment:
// object positions and clear request in, one pixel write per clock out.
interface display_manager_if;
    logic        clear_en;
    logic [10:0] pipe1_x;
    logic [10:0] pipe1_y;
    logic [10:0] pipe2_x;
    logic [10:0] pipe2_y;
    logic [10:0] bird_x;
    logic [10:0] bird_y;
    logic [10:0] x;
    logic [10:0] y;
    logic        color;
    logic        clear_done;

    modport master (
        output clear_en, pipe1_x, pipe1_y, pipe2_x, pipe2_y, bird_x, bird_y,
        input  x, y, color, clear_done
    );

    modport slave (
        input  clear_en, pipe1_x, pipe1_y, pipe2_x, pipe2_y, bird_x, bird_y,
        output x, y, color, clear_done
    );
endinterface

// File: rtl/display_manager.sv
// display_manager: pixel-stream sequencer for a 1-bit frame buffer.
// Cycles CLEAR -> PIPE1 -> PIPE2 -> BIRD (-> CLEAR or PIPE1), emitting one
// (x, y, color) write per clock. Optional macro PIPE_CLIP_EN forces pipe
// pixels whose column falls outside 1..SCREEN_W-2 onto column 0.
module display_manager #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PIPE_W   = 40,
    parameter int GAP_H    = 120,
    parameter int BIRD_SZ  = 16
) (
    input logic              clk,
    input logic              reset,
    display_manager_if.slave dif
);
    typedef enum logic [1:0] {S_CLEAR, S_PIPE1, S_PIPE2, S_BIRD} state_t;

    localparam logic [10:0] SCR_LAST_C  = 11'(SCREEN_W - 1);
    localparam logic [10:0] SCR_LAST_R  = 11'(SCREEN_H - 1);
    localparam logic [10:0] PIPE_LAST_C = 11'(PIPE_W - 1);
    localparam logic [10:0] BIRD_LAST   = 11'(BIRD_SZ - 1);
    localparam logic [11:0] GAP         = 12'(GAP_H);
`ifdef PIPE_CLIP_EN
    localparam logic [10:0] CLIP_HI     = 11'(SCREEN_W - 2);
`endif

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d, row_q, row_d;
    logic [10:0] ox_q, ox_d, oy_q, oy_d;
    logic        entry_q, entry_d;
    logic [10:0] sel_x, sel_y, obj_x, obj_y, last_c, last_r;
    logic [10:0] pix_x, pix_y, x_o, y_o;
    logic        scan_done, in_gap, color_o, done_o;

    // Pick the object source and scan extent for the active state; on the
    // entry cycle the live inputs are used, afterwards the latched copy.
    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        last_c = SCR_LAST_C;
        last_r = SCR_LAST_R;
        case (state_q)
            S_PIPE1: begin
                sel_x  = dif.pipe1_x;
                sel_y  = dif.pipe1_y;
                last_c = PIPE_LAST_C;
            end
            S_PIPE2: begin
                sel_x  = dif.pipe2_x;
                sel_y  = dif.pipe2_y;
                last_c = PIPE_LAST_C;
            end
            S_BIRD: begin
                sel_x  = dif.bird_x;
                sel_y  = dif.bird_y;
                last_c = BIRD_LAST;
                last_r = BIRD_LAST;
            end
            default: ;
        endcase
        obj_x     = entry_q ? sel_x : ox_q;
        obj_y     = entry_q ? sel_y : oy_q;
        scan_done = (col_q == last_c) && (row_q == last_r);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // Next state: advance only on the last pixel of the current scan
    always_comb begin
        state_d = state_q;
        if (scan_done) begin
            case (state_q)
                S_CLEAR: state_d = S_PIPE1;
                S_PIPE1: state_d = S_PIPE2;
                S_PIPE2: state_d = S_BIRD;
                S_BIRD:  state_d = dif.clear_en ? S_CLEAR : S_PIPE1;
                default: state_d = S_CLEAR;
            endcase
        end
    end

    // Row-major scan counters (column fastest) and coordinate hold
    always_comb begin
        col_d = col_q + 11'd1;
        row_d = row_q;
        if (scan_done) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == last_c) begin
            col_d = '0;
            row_d = row_q + 11'd1;
        end
        ox_d    = obj_x;
        oy_d    = obj_y;
        entry_d = (state_d != state_q);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            entry_q <= 1'b1;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            entry_q <= entry_d;
        end
    end

    // Output decode: pixel position and value for the current scan step
    always_comb begin
        pix_x   = obj_x + col_q;
        pix_y   = obj_y + row_q;
        in_gap  = ({1'b0, row_q} >= {1'b0, obj_y}) &&
                  ({1'b0, row_q} < ({1'b0, obj_y} + GAP));
        x_o     = col_q;
        y_o     = row_q;
        color_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_CLEAR: done_o = scan_done;
            S_PIPE1, S_PIPE2: begin
                x_o     = pix_x;
                color_o = ~in_gap;
`ifdef PIPE_CLIP_EN
                if (pix_x == 11'd0 || pix_x > CLIP_HI) x_o = '0;
`endif
            end
            S_BIRD: begin
                x_o     = pix_x;
                y_o     = pix_y;
                color_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign dif.x          = x_o;
    assign dif.y          = y_o;
    assign dif.color      = color_o;
    assign dif.clear_done = done_o;

endmodule

// File: tb/tb_display_manager.sv
// Scoreboard bench for display_manager on a reduced screen. The driver
// pushes the full expected pixel list of each draw as it starts; a negedge
// monitor pops and compares one pixel per clock.
module tb_display_manager;
    localparam int W = 64, H = 48, PW = 8, GAP = 12, BS = 4;
    localparam int S_CLR = 0, S_P1 = 1, S_P2 = 2, S_BD = 3;

    typedef struct { int x; int y; int c; int d; } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    display_manager_if dif();

    display_manager #(.SCREEN_W(W), .SCREEN_H(H), .PIPE_W(PW), .GAP_H(GAP), .BIRD_SZ(BS))
        dut (.clk(clk), .reset(reset), .dif(dif));

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    bit   mon_en = 1'b0;
    pix_t mon_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every clock the DUT presents exactly one pixel
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_underrun actual=pixel expected=none");
            end else begin
                mon_p = exp_q.pop_front();
                chk("x", {21'b0, dif.x}, mon_p.x);
                chk("y", {21'b0, dif.y}, mon_p.y);
                chk("color", {31'b0, dif.color}, mon_p.c);
                chk("clear_done", {31'b0, dif.clear_done}, mon_p.d);
            end
        end
    end

    function automatic int seg_len(input int k);
        if (k == S_CLR) return W * H;
        if (k == S_BD)  return BS * BS;
        return PW * H;
    endfunction

    // Reference model: enumerate the draw straight from the screen rules
    function automatic void push_seg(input int k);
        pix_t p;
        int ox, oy, xx;
        ox = 0;
        oy = 0;
        if (k == S_P1) begin ox = int'(dif.pipe1_x); oy = int'(dif.pipe1_y); end
        if (k == S_P2) begin ox = int'(dif.pipe2_x); oy = int'(dif.pipe2_y); end
        if (k == S_BD) begin ox = int'(dif.bird_x);  oy = int'(dif.bird_y);  end
        if (k == S_CLR) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    p.x = c; p.y = r; p.c = 0;
                    p.d = (c == W - 1 && r == H - 1) ? 1 : 0;
                    exp_q.push_back(p);
                end
        end else if (k == S_BD) begin
            for (int r = 0; r < BS; r++)
                for (int c = 0; c < BS; c++) begin
                    p.x = (ox + c) % 2048; p.y = (oy + r) % 2048; p.c = 1; p.d = 0;
                    exp_q.push_back(p);
                end
        end else begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < PW; c++) begin
                    xx = (ox + c) % 2048;
`ifdef PIPE_CLIP_EN
                    if (xx < 1 || xx > W - 2) xx = 0;
`endif
                    p.x = xx; p.y = r; p.d = 0;
                    p.c = (r >= oy && r < oy + GAP) ? 0 : 1;
                    exp_q.push_back(p);
                end
        end
    endfunction

    function automatic logic [10:0] rand_x();
        case ($urandom_range(0, 3))
            0:       return 11'(W - PW / 2 + $urandom_range(0, 3));
            1:       return 11'(2048 - PW / 2 + $urandom_range(0, 2));
            2:       return 11'($urandom_range(0, W - PW));
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic set_obj(input int k, input bit directed);
        case (k)
            S_P1: begin
                dif.pipe1_x = directed ? 11'd10 : rand_x();
                dif.pipe1_y = directed ? 11'd20 : 11'($urandom_range(0, H));
            end
            S_P2: begin
                dif.pipe2_x = directed ? 11'(W - 4) : rand_x();
                dif.pipe2_y = directed ? 11'd0 : 11'($urandom_range(0, H));
            end
            S_BD: begin
                dif.bird_x = directed ? 11'd10 : 11'($urandom_range(0, 2047));
                dif.bird_y = directed ? 11'd10 : 11'($urandom_range(0, 2047));
            end
            default: ;
        endcase
    endtask

    // Mid-draw input churn: must not disturb the latched objects
    task automatic perturb();
        if ($urandom_range(0, 3) == 0) begin
            dif.pipe1_x = 11'($urandom); dif.pipe1_y = 11'($urandom);
            dif.pipe2_x = 11'($urandom); dif.pipe2_y = 11'($urandom);
            dif.bird_x  = 11'($urandom); dif.bird_y  = 11'($urandom);
        end
        dif.clear_en = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int seg, nxt, n, nseg, birds;
        bit aborted, just_aborted;
        dif.clear_en = 1'b0;
        dif.pipe1_x = '0; dif.pipe1_y = '0;
        dif.pipe2_x = '0; dif.pipe2_y = '0;
        dif.bird_x  = '0; dif.bird_y  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", {21'b0, dif.x}, 0);
        chk("reset_y", {21'b0, dif.y}, 0);
        chk("reset_color", {31'b0, dif.color}, 0);
        chk("reset_clear_done", {31'b0, dif.clear_done}, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        seg = S_CLR;
        nxt = S_P1;
        nseg = 0;
        birds = 0;
        aborted = 1'b0;
        while (nseg < 30) begin
            just_aborted = 1'b0;
            push_seg(seg);
            n = seg_len(seg);
            for (int i = 0; i < n; i++) begin
                if (!aborted && seg == S_P2 && nseg >= 8 && i == n / 2) begin
                    #2 reset = 1'b1;
                    #1;
                    chk("async_reset_x", {21'b0, dif.x}, 0);
                    chk("async_reset_y", {21'b0, dif.y}, 0);
                    chk("async_reset_color", {31'b0, dif.color}, 0);
                    exp_q.delete();
                    @(posedge clk);
                    #1 reset = 1'b0;
                    aborted = 1'b1;
                    just_aborted = 1'b1;
                    break;
                end
                if (i == n - 1) begin
                    dif.clear_en = 1'($urandom_range(0, 1));
                    case (seg)
                        S_CLR: nxt = S_P1;
                        S_P1:  nxt = S_P2;
                        S_P2:  nxt = S_BD;
                        default: begin
                            if (birds == 0)      dif.clear_en = 1'b0;
                            else if (birds == 1) dif.clear_en = 1'b1;
                            else                 dif.clear_en = ($urandom_range(0, 3) == 0);
                            birds++;
                            nxt = dif.clear_en ? S_CLR : S_P1;
                        end
                    endcase
                    set_obj(nxt, nseg < 3);
                end else if (i > 0) begin
                    perturb();
                end
                @(posedge clk);
                #1;
            end
            seg = just_aborted ? S_CLR : nxt;
            nseg++;
        end
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
